// File: rtl/output_arbiter_pkg.sv
// Shared types and constants for the feedback-output arbiter.
// FSM states, one-hot grant codes and the game-over note index.
package output_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        GAP,
        ALARM
    } state_t;

    localparam logic [2:0] G_GO   = 3'b100;
    localparam logic [2:0] G_SIM  = 3'b010;
    localparam logic [2:0] G_PLY  = 3'b001;
    localparam logic [2:0] G_NONE = 3'b000;

    localparam logic [1:0] NOTE_GAMEOVER = 2'b11;

endpackage

// File: rtl/output_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface output_arbiter_if;

    logic       go_req;
    logic       sim_req;
    logic [1:0] sim_num;
    logic       ply_req;
    logic [1:0] ply_num;
    logic [2:0] grant;
    logic [1:0] num;
    logic       pressed;
    logic       game_over;
    logic       sim_done;
    logic       ply_done;
    logic       ply_lost;

    modport master (
        output go_req, sim_req, sim_num, ply_req, ply_num,
        input  grant, num, pressed, game_over, sim_done, ply_done, ply_lost
    );

    modport slave (
        input  go_req, sim_req, sim_num, ply_req, ply_num,
        output grant, num, pressed, game_over, sim_done, ply_done, ply_lost
    );

endinterface

// File: rtl/output_arbiter_arb_timer.sv
// Loadable saturating up-counter with a >= compare against a runtime limit;
// shared between note-duration and inter-note-gap timing.
module arb_timer #(
    parameter int unsigned CNT_W = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             ge
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(1);
        end else if (en && (count < limit)) begin
            count <= count + 1'b1;
        end
    end

    assign ge = (count >= limit);

endmodule

// File: rtl/output_arbiter.sv
// Fixed-priority scheduler of the LED/tone/speaker chain: game-over > Simon > player,
// with a minimum note length and a silent gap between notes.
module output_arbiter
    import output_arbiter_pkg::*;
#(
    parameter int unsigned NOTE_MIN = 25000000,
    parameter int unsigned GAP_CYC  = 5000000,
    parameter int unsigned CNT_W    = 25
) (
    input logic            clk,
    input logic            reset,
    output_arbiter_if.slave bus
);

    state_t     state;
    logic [2:0] grant_r;
    logic [1:0] num_r;
    logic       pressed_r;
    logic       game_over_r;
    logic       sim_done_r;
    logic       ply_done_r;
    logic       ply_lost_r;
    logic       ply_q;

    logic             tmr_load;
    logic             tmr_en;
    logic             tmr_ge;
    logic [CNT_W-1:0] tmr_limit;
    logic             granted_req;
    logic             play_exit;
    logic             ply_rise;
    logic             ply_blocked;

    assign granted_req = (grant_r == G_SIM) ? bus.sim_req : bus.ply_req;
    assign play_exit   = tmr_ge && !granted_req;
    assign ply_rise    = bus.ply_req && !ply_q;
    assign tmr_limit   = (state == PLAY) ? CNT_W'(NOTE_MIN) : CNT_W'(GAP_CYC);

    always_comb begin
        ply_blocked = 1'b0;
        case (state)
            IDLE:  ply_blocked = bus.go_req || bus.sim_req;
            PLAY:  ply_blocked = (grant_r == G_SIM);
            GAP:   ply_blocked = 1'b1;
            ALARM: ply_blocked = 1'b1;
        endcase
    end

    // Timer restarts at 1 on every entry into PLAY or GAP; go_req overrides all loads.
    always_comb begin
        tmr_load = 1'b0;
        tmr_en   = (state == PLAY) || (state == GAP);
        if (!bus.go_req) begin
            case (state)
                IDLE:  tmr_load = bus.sim_req || bus.ply_req;
                PLAY:  tmr_load = play_exit;
                GAP:   tmr_load = 1'b0;
                ALARM: tmr_load = 1'b1;
            endcase
        end
    end

    arb_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .en    (tmr_en),
        .limit (tmr_limit),
        .ge    (tmr_ge)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            grant_r     <= G_NONE;
            num_r       <= '0;
            pressed_r   <= 1'b0;
            game_over_r <= 1'b0;
            sim_done_r  <= 1'b0;
            ply_done_r  <= 1'b0;
            ply_lost_r  <= 1'b0;
            ply_q       <= 1'b0;
        end else begin
            sim_done_r <= 1'b0;
            ply_done_r <= 1'b0;
            ply_q      <= bus.ply_req;
            ply_lost_r <= ply_rise && ply_blocked;
            if (bus.go_req) begin
                state       <= ALARM;
                grant_r     <= G_GO;
                num_r       <= NOTE_GAMEOVER;
                pressed_r   <= 1'b1;
                game_over_r <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.sim_req) begin
                            state     <= PLAY;
                            grant_r   <= G_SIM;
                            num_r     <= bus.sim_num;
                            pressed_r <= 1'b1;
                        end else if (bus.ply_req) begin
                            state     <= PLAY;
                            grant_r   <= G_PLY;
                            num_r     <= bus.ply_num;
                            pressed_r <= 1'b1;
                        end
                    end
                    PLAY: begin
                        if (play_exit) begin
                            state      <= GAP;
                            grant_r    <= G_NONE;
                            pressed_r  <= 1'b0;
                            sim_done_r <= (grant_r == G_SIM);
                            ply_done_r <= (grant_r == G_PLY);
                        end
                    end
                    GAP: begin
                        if (tmr_ge) begin
                            state <= IDLE;
                        end
                    end
                    ALARM: begin
                        state       <= GAP;
                        grant_r     <= G_NONE;
                        pressed_r   <= 1'b0;
                        game_over_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.grant     = grant_r;
    assign bus.num       = num_r;
    assign bus.pressed   = pressed_r;
    assign bus.game_over = game_over_r;
    assign bus.sim_done  = sim_done_r;
    assign bus.ply_done  = ply_done_r;
    assign bus.ply_lost  = ply_lost_r;

endmodule

// File: tb/tb_output_arbiter.sv
// Directed bench for output_arbiter with NOTE_MIN=4, GAP_CYC=2; expected
// values are hand-derived per cycle and checked with immediate assertions.
module tb_output_arbiter;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    output_arbiter_if bus();

    output_arbiter #(
        .NOTE_MIN(4),
        .GAP_CYC (2),
        .CNT_W   (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_o(input string tag, input logic [2:0] g, input logic [1:0] n,
                            input logic p, input logic go, input logic sd,
                            input logic pd, input logic pl);
        chk({tag, ".grant"},     {5'd0, bus.grant},     {5'd0, g});
        chk({tag, ".num"},       {6'd0, bus.num},       {6'd0, n});
        chk({tag, ".pressed"},   {7'd0, bus.pressed},   {7'd0, p});
        chk({tag, ".game_over"}, {7'd0, bus.game_over}, {7'd0, go});
        chk({tag, ".sim_done"},  {7'd0, bus.sim_done},  {7'd0, sd});
        chk({tag, ".ply_done"},  {7'd0, bus.ply_done},  {7'd0, pd});
        chk({tag, ".ply_lost"},  {7'd0, bus.ply_lost},  {7'd0, pl});
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        bus.go_req  = 1'b0;
        bus.sim_req = 1'b0;
        bus.sim_num = 2'd0;
        bus.ply_req = 1'b0;
        bus.ply_num = 2'd0;

        step();
        step();
        expect_o("reset", 3'b000, 2'd0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        step();
        expect_o("idle", 3'b000, 2'd0, 0, 0, 0, 0, 0);

        // Simon note, request held one cycle: full 4-cycle note then 2-cycle gap
        bus.sim_req = 1'b1;
        bus.sim_num = 2'd2;
        step();
        expect_o("sim.grant", 3'b010, 2'd2, 1, 0, 0, 0, 0);
        bus.sim_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_o("sim.hold", 3'b010, 2'd2, 1, 0, 0, 0, 0);
        end
        step();
        expect_o("sim.done", 3'b000, 2'd2, 0, 0, 1, 0, 0);
        step();
        expect_o("sim.gap", 3'b000, 2'd2, 0, 0, 0, 0, 0);
        step();
        expect_o("sim.idle", 3'b000, 2'd2, 0, 0, 0, 0, 0);

        // Player note held 10 cycles; ply_num change mid-note is ignored
        bus.ply_req = 1'b1;
        bus.ply_num = 2'd1;
        for (int i = 0; i < 10; i++) begin
            step();
            expect_o("ply.hold", 3'b001, 2'd1, 1, 0, 0, 0, 0);
            if (i == 2) bus.ply_num = 2'd3;
        end
        bus.ply_req = 1'b0;
        step();
        expect_o("ply.done", 3'b000, 2'd1, 0, 0, 0, 1, 0);
        step();
        expect_o("ply.gap", 3'b000, 2'd1, 0, 0, 0, 0, 0);
        step();
        expect_o("ply.idle", 3'b000, 2'd1, 0, 0, 0, 0, 0);

        // Simultaneous sim and ply in IDLE: sim wins, ply_lost once, ply served later
        bus.sim_req = 1'b1;
        bus.sim_num = 2'd0;
        bus.ply_req = 1'b1;
        bus.ply_num = 2'd2;
        step();
        expect_o("both.sim", 3'b010, 2'd0, 1, 0, 0, 0, 1);
        bus.sim_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_o("both.hold", 3'b010, 2'd0, 1, 0, 0, 0, 0);
        end
        step();
        expect_o("both.done", 3'b000, 2'd0, 0, 0, 1, 0, 0);
        step();
        expect_o("both.gap", 3'b000, 2'd0, 0, 0, 0, 0, 0);
        step();
        expect_o("both.idle", 3'b000, 2'd0, 0, 0, 0, 0, 0);
        step();
        expect_o("both.ply", 3'b001, 2'd2, 1, 0, 0, 0, 0);

        // Game-over preempts player note at its second cycle; no ply_done
        step();
        expect_o("go.ply2", 3'b001, 2'd2, 1, 0, 0, 0, 0);
        bus.go_req  = 1'b1;
        bus.ply_req = 1'b0;
        step();
        expect_o("go.alarm", 3'b100, 2'd3, 1, 1, 0, 0, 0);
        step();
        expect_o("go.hold", 3'b100, 2'd3, 1, 1, 0, 0, 0);
        bus.go_req = 1'b0;
        step();
        expect_o("go.gap1", 3'b000, 2'd3, 0, 0, 0, 0, 0);

        // ply_req rising during GAP: lost pulse, served once IDLE is reached
        bus.ply_req = 1'b1;
        bus.ply_num = 2'd1;
        step();
        expect_o("gap.lost", 3'b000, 2'd3, 0, 0, 0, 0, 1);
        step();
        expect_o("gap.idle", 3'b000, 2'd3, 0, 0, 0, 0, 0);
        step();
        expect_o("gap.ply", 3'b001, 2'd1, 1, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a note, between clock edges
        step();
        expect_o("arst.pre", 3'b001, 2'd1, 1, 0, 0, 0, 0);
        #3;
        reset = 1'b0;
        #1;
        expect_o("arst.now", 3'b000, 2'd0, 0, 0, 0, 0, 0);
        bus.ply_req = 1'b0;
        step();
        expect_o("arst.held", 3'b000, 2'd0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        step();
        expect_o("arst.idle", 3'b000, 2'd0, 0, 0, 0, 0, 0);
        bus.sim_req = 1'b1;
        bus.sim_num = 2'd1;
        step();
        expect_o("arst.sim", 3'b010, 2'd1, 1, 0, 0, 0, 0);
        bus.sim_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_o("race.hold", 3'b010, 2'd1, 1, 0, 0, 0, 0);
        end

        // go_req arrives on the very edge the note would end: alarm, no sim_done
        bus.go_req = 1'b1;
        step();
        expect_o("race.alarm", 3'b100, 2'd3, 1, 1, 0, 0, 0);
        bus.go_req = 1'b0;
        step();
        expect_o("race.gap1", 3'b000, 2'd3, 0, 0, 0, 0, 0);
        step();
        expect_o("race.gap2", 3'b000, 2'd3, 0, 0, 0, 0, 0);
        step();
        expect_o("race.idle", 3'b000, 2'd3, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/output_arbiter.md
Name: output_arbiter

Overview:
- Schedules the shared feedback resource (LED driver, tone generator, speaker) between three requesters: game-over alarm, Simon pattern playback and player button echo.
- Fixed priority; enforces a minimum note duration and a silent inter-note gap.
- Game-over preempts everything.
- Sits between the Simon/button-interpreter logic and the num-to-LED / num-to-frequency / speaker chain, and drives their num/pressed inputs.

Parameters:
- NOTE_MIN, 25000000, minimum clk cycles a granted note stays pressed (≥1)
- GAP_CYC, 5000000, clk cycles of silence after a note before the next grant (≥1)
- CNT_W, 25, counter width; must hold max(NOTE_MIN, GAP_CYC)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- go_req  in  1  game-over request, level
- sim_req  in  1  Simon playback request, level
- sim_num  in  2  Simon note index
- ply_req  in  1  player press request, level
- ply_num  in  2  player note index
- grant  out  3  one-hot grant {go, sim, ply}; 000 when nobody is granted
- num  out  2  note index to the LED/frequency chain
- pressed  out  1  note active; drives LED enable and speaker play
- game_over  out  1  high while go is granted
- sim_done  out  1  1-cycle pulse when a Simon note finishes (PLAY→GAP)
- ply_done  out  1  1-cycle pulse when a player note finishes
- ply_lost  out  1  1-cycle pulse on a rising edge of ply_req while ply is not grantable

Behaviour:
- All flops use async reset (reset=0). Reset values:
  - state=IDLE, counter=0
  - grant=000, num=00, pressed=0, game_over=0
  - all pulse outputs 0
- States: IDLE, PLAY, GAP, ALARM.
- IDLE: evaluate requests each cycle with priority go > sim > ply. Next cycle:
  - go_req → ALARM.
  - sim_req → PLAY, grant=010, num latched from sim_num.
  - ply_req → PLAY, grant=001, num latched from ply_num.
  - In both PLAY cases: pressed=1, counter=1.
  - Grant latency is exactly 1 cycle after the request is sampled.
- PLAY:
  - Counter increments, saturating at NOTE_MIN.
  - num is frozen; input num changes are ignored.
  - Exit to GAP when counter ≥ NOTE_MIN and the granted req is low, on the same edge the condition is true. On exit: pressed=0, grant=000, counter=1, and the matching *_done pulse fires that cycle.
  - A req that stays high holds the note indefinitely.
  - A req that drops before NOTE_MIN still gets the full NOTE_MIN.
- GAP:
  - pressed=0; counter increments.
  - When counter = GAP_CYC, go to IDLE.
  - Requests are not queued; a level still high at IDLE is served then.
- ALARM (entered from any state when go_req=1, including mid-PLAY and mid-GAP):
  - grant=100, game_over=1, pressed=1, num=11.
  - A preempted note gives no done pulse.
  - Leave only when go_req=0: go to GAP with counter=1, pressed=0, game_over=0.
- ply_lost:
  - Needs a registered copy of ply_req for edge detection.
  - Fires when a ply_req rising edge occurs in state PLAY (sim granted), GAP or ALARM, or in IDLE together with go_req or sim_req.
  - Does not fire while ply itself is granted.
- Simultaneous events:
  - A go_req rising on the same cycle PLAY would exit → ALARM wins, no done pulse.
  - sim_req and ply_req rising together in IDLE → sim granted, ply_lost=1.
- Reset asserted mid-note: outputs drop immediately (asynchronously) to reset values.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE, PLAY, GAP, ALARM)
  - grant one-hot constants (G_GO=100, G_SIM=010, G_PLY=001, G_NONE=000)
  - NOTE_GAMEOVER=2'b11
- One sub-module is natural: arb_timer, a loadable saturating up-counter (load-to-1, enable, ≥ compare against a limit input), used for both NOTE_MIN and GAP_CYC.
- Priority encode and FSM stay in output_arbiter.

Test Plan:
(Benches use NOTE_MIN=4, GAP_CYC=2.)
- Reset release, sim_req=1 with sim_num=2 for 1 cycle → grant=010, num=2, pressed=1 for exactly 4 cycles starting 1 cycle after the request; sim_done on the PLAY→GAP edge; pressed=0 for 2 cycles; back to IDLE.
- ply_req=1 with ply_num=1 held 10 cycles → pressed high 10 cycles; ply_done after ply_req falls; ply_num changes mid-note don't alter num=1.
- sim_req and ply_req asserted the same cycle in IDLE → grant=010, ply_lost=1 once; after sim finishes plus gap, a still-high ply_req gets grant=001.
- go_req asserted at cycle 2 of a player note → next cycle grant=100, num=3, game_over=1, pressed=1; no ply_done; go_req dropped → 2-cycle gap, then IDLE.
- reset driven low mid-PLAY, asynchronously with no clk edge → pressed, grant and game_over are 0 immediately; after release, state is IDLE.
- ply_req rising edge during GAP → ply_lost pulse, no grant until IDLE; grant=001 the cycle after IDLE if still high.
